mem_stage_responder: RTL

//  MEM-stage data-memory responder: consumes MemRead/MemWrite/addr/data driven by the EX/MEM pipeline register.

---
 rtl/mem_stage_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_stage_responder.sv
// MEM-stage data-memory responder: serves each aligned access with a fixed latency,
// stalls the upstream pipeline meanwhile and pulses done_o toward MEM/WB.
module mem_stage_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        misalign_o
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CW     = $clog2(LATENCY + 1);
  localparam bit          DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_re;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_aligned;
  logic            w_start;
  logic [AW-1:0]   w_idx;
  logic            w_commit;
  logic            w_cm_re;
  logic            w_cm_we;
  logic [AW-1:0]   w_cm_idx;
  logic [31:0]     w_cm_data;
  logic            w_unused_addr;

  assign w_req         = MemRead_i | MemWrite_i;
  assign w_aligned     = (addr_i[1:0] == 2'b00);
  assign w_idx         = addr_i[AW+1:2];
  assign w_start       = (r_state == S_IDLE) && w_req && w_aligned;
  assign w_unused_addr = ^addr_i[31:AW+2];

  assign stall_o = w_start || (r_state == S_BUSY);

  // With a single-cycle latency the access completes at the request edge,
  // so it commits straight from the live inputs instead of the latched copy.
  always_comb begin
    w_commit  = 1'b0;
    w_cm_re   = r_re;
    w_cm_we   = r_we;
    w_cm_idx  = r_idx;
    w_cm_data = r_wdata;
    if (DIRECT) begin
      w_commit  = w_start;
      w_cm_re   = MemRead_i;
      w_cm_we   = MemWrite_i;
      w_cm_idx  = w_idx;
      w_cm_data = data_i;
    end else begin
      w_commit  = (r_state == S_BUSY) && (r_count == CW'(1));
    end
  end

  // Array is deliberately never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_commit && w_cm_we)
      r_mem[w_cm_idx] <= w_cm_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      data_o     <= '0;
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_aligned) begin
            misalign_o <= 1'b1;
          end else if (w_start) begin
            r_re    <= MemRead_i;
            r_we    <= MemWrite_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
            r_count <= CW'(LATENCY - 1);
            r_state <= DIRECT ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          r_count <= r_count - CW'(1);
          if (w_commit) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        done_o <= 1'b1;
        if (w_cm_re) data_o <= r_mem[w_cm_idx];
      end
    end
  end

endmodule
